// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, valid/ready holding register.
// rx_valid rises HALF+9*DIV+3 cycles after the start edge; a byte arriving while the register is full is dropped with an overrun pulse.
module uart_rx_core #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV  = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  generate
    if (DIV < 8) begin : g_div_check
      $error("uart_rx_core: clock/baud ratio too small, DIV must be >= 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  logic          sync1_q;
  logic          rxs_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          dlv_evt_q, dlv_evt_d;
  logic          ferr_evt_q, ferr_evt_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q;
  logic          busy_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rxs_q   <= sync1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sh_d       = sh_q;
    dlv_evt_d  = 1'b0;
    ferr_evt_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is already high again at mid-bit was a glitch.
          state_d = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d = '0;
          sh_d  = {rxs_q, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d = '0;
          // Leaving at mid-stop-bit keeps us ready for a back-to-back start edge.
          if (rxs_q) begin
            dlv_evt_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            ferr_evt_d = 1'b1;
            state_d    = S_BRK;
          end
        end
      end
      S_BRK: begin
        cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      dlv_evt_q  <= 1'b0;
      ferr_evt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      dlv_evt_q  <= dlv_evt_d;
      ferr_evt_q <= ferr_evt_d;
    end
  end

  // sh_q is untouched until the next frame's first data sample, so it is still valid one cycle after STOP.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (dlv_evt_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = sh_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= ferr_evt_q;
      busy_q      <= (state_q != S_IDLE);
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized frames at +-2 % baud,
// expected bytes queued at send time and popped by an independent monitor on each handshake.
module tb_uart_rx_core;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int DIV    = 100;
  localparam int HALF   = 50;
  localparam int DLY    = 1 + 3 + HALF + 9 * DIV;  // fall_cyc to rx_valid rise, in cycle counts

  logic       clk_in   = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx_in    = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int valid_rise_cyc = -100000;
  int busy_rise_cyc  = -100000;
  int fall_cyc = 0;
  logic prev_valid = 1'b0, prev_busy = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: consumes expectations on handshakes and tallies flag pulses.
  always @(negedge clk_in) begin
    if (rx_valid && rx_ready) begin
      if (exp_q.size() == 0) check("unexpected_byte", int'(rx_data), -1);
      else check("byte", int'(rx_data), int'(exp_q.pop_front()));
    end
    if (frame_err) begin
      ferr_cnt++;
      check("ferr_single_cycle", int'(prev_ferr), 0);
      check("flags_exclusive", int'(overrun), 0);
    end
    if (overrun) begin
      ovr_cnt++;
      check("ovr_single_cycle", int'(prev_ovr), 0);
    end
    if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
    if (busy && !prev_busy) busy_rise_cyc = cyc;
    prev_valid = rx_valid;
    prev_busy  = busy;
    prev_ferr  = frame_err;
    prev_ovr   = overrun;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bitc);
    fall_cyc = cyc;
    rx_in = 1'b0;
    wait_cyc(bitc);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      wait_cyc(bitc);
    end
    rx_in = stop;
    wait_cyc(bitc);
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    wait_cyc(1);
    rx_ready = 1'b0;
  endtask

  int f0, o0, nb, nbad, t0a;
  bit done;
  logic [7:0] r_b;
  int r_bitc;
  bit r_bad;
  logic [7:0] c3;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk_in);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    wait_cyc(5);

    // Single byte, latency
    f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, DIV);
    check_range("t1_busy_latency", busy_rise_cyc - fall_cyc, 3, 5);
    check_range("t1_valid_latency", valid_rise_cyc - fall_cyc, DLY - 1, DLY + 1);
    check("t1_valid", int'(rx_valid), 1);
    check("t1_data", int'(rx_data), 8'hA5);
    check("t1_no_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    pulse_ready();
    check("t1_cleared", int'(rx_valid), 0);
    check("t1_drained", exp_q.size(), 0);

    // Back-to-back with rx_ready tied high
    f0 = ferr_cnt; o0 = ovr_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
    send_frame(8'h00, 1'b1, DIV);
    send_frame(8'hFF, 1'b1, DIV);
    send_frame(8'h55, 1'b1, DIV);
    wait_cyc(200);
    check("t2_drained", exp_q.size(), 0);
    check("t2_ferr", ferr_cnt - f0, 0);
    check("t2_ovr", ovr_cnt - o0, 0);
    rx_ready = 1'b0;

    // Glitch shorter than half a bit
    f0 = ferr_cnt; o0 = ovr_cnt; nb = 0;
    rx_in = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_in);
      if (busy) nb++;
      if (i == 29) rx_in = 1'b1;
    end
    check_range("t3_busy_cycles", nb, HALF - 1, HALF + 1);
    check("t3_no_valid", int'(rx_valid), 0);
    check("t3_no_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    check("t3_idle", int'(busy), 0);
    wait_cyc(5);

    // Framing error followed by break
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h3C, 1'b0, DIV);
    wait_cyc(5 * DIV);
    check("t4_busy_in_break", int'(busy), 1);
    rx_in = 1'b1;
    wait_cyc(10);
    check("t4_idle_after", int'(busy), 0);
    check("t4_one_ferr", ferr_cnt - f0, 1);
    check("t4_no_ovr", ovr_cnt - o0, 0);
    check("t4_no_valid", int'(rx_valid), 0);

    // Overrun with consumer stalled
    o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, DIV);
    send_frame(8'h22, 1'b1, DIV);
    wait_cyc(20);
    check("t5_one_ovr", ovr_cnt - o0, 1);
    check("t5_data_kept", int'(rx_data), 8'h11);
    check("t5_valid", int'(rx_valid), 1);
    pulse_ready();
    check("t5_drained", exp_q.size(), 0);

    // Accept exactly in the delivery cycle of the second byte
    o0 = ovr_cnt;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    t0a = cyc;
    fork
      begin
        send_frame(8'h11, 1'b1, DIV);
        send_frame(8'h22, 1'b1, DIV);
      end
      begin
        repeat (10 * DIV + DLY - 1) @(posedge clk_in);
        #1 rx_ready = 1'b1;
        @(posedge clk_in);
        #1 rx_ready = 1'b0;
      end
    join
    check("t5b_no_ovr", ovr_cnt - o0, 0);
    check("t5b_data", int'(rx_data), 8'h22);
    check("t5b_valid", int'(rx_valid), 1);
    check("t5b_one_left", exp_q.size(), 1);
    pulse_ready();
    check("t5b_drained", exp_q.size(), 0);

    // Reset mid-frame with a byte already held
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h5A, 1'b1, DIV);
    wait_cyc(10);
    c3 = 8'hC3;
    rx_in = 1'b0;
    wait_cyc(DIV);
    for (int i = 0; i < 4; i++) begin
      rx_in = c3[i];
      wait_cyc(DIV);
    end
    rx_in = c3[4];
    wait_cyc(HALF);
    check("t6_busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_data", int'(rx_data), 0);
    check("t6_rst_valid", int'(rx_valid), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_flags", int'(frame_err) + int'(overrun), 0);
    rx_in = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(5);
    rx_ready = 1'b1;
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, DIV);
    wait_cyc(100);
    check("t6_drained", exp_q.size(), 0);
    check("t6_no_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    rx_ready = 1'b0;

    // Randomized frames, +-2 % baud, occasional bad stop bit
    f0 = ferr_cnt; o0 = ovr_cnt; nbad = 0; done = 1'b0;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          r_b    = 8'($urandom);
          r_bitc = 98 + 2 * int'($urandom_range(0, 2));
          r_bad  = ($urandom_range(0, 4) == 0);
          if (r_bad) begin
            send_frame(r_b, 1'b0, r_bitc);
            wait_cyc(int'($urandom_range(1, 300)));
            rx_in = 1'b1;
            wait_cyc(20);
            nbad++;
          end else begin
            exp_q.push_back(r_b);
            send_frame(r_b, 1'b1, r_bitc);
            if ($urandom_range(0, 1) == 1) wait_cyc(int'($urandom_range(1, 150)));
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk_in);
          #1 rx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rx_ready = 1'b1;
    wait_cyc(300);
    check("t7_drained", exp_q.size(), 0);
    check("t7_ferr_count", ferr_cnt - f0, nbad);
    check("t7_no_ovr", ovr_cnt - o0, 0);
    rx_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Receive half of the UART: oversamples the asynchronous `ck_io1` serial line in the `clk_in` domain, recovers 8N1 frames and hands each byte to the host logic through a valid/ready holding register. It pairs with the transmit path inside `uart_top`, decoding the serial stream that a transmitter of the same baud rate produces. It also flags framing errors and overruns so that `led` status logic can display them.

## Interface
- `CLK_FREQ_HZ`, 100_000_000, frequency of `clk_in`.
- `BAUD_RATE`, 115200, line rate. Derived values:
  - DIV = (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE, integer rounding.
  - HALF = DIV/2, truncated.
  - DIV must be ≥ 8; enforce with an elaboration-time check.

- `clk_in`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `rx_in`  input  1  raw serial line, idle high, asynchronous to `clk_in`.
- `rx_data`  output  8  received byte, LSB = first data bit.
- `rx_valid`  output  1  `rx_data` holds an unconsumed byte.
- `rx_ready`  input  1  consumer accepts the byte when `rx_valid & rx_ready`.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun`  output  1  one-cycle pulse: a good byte was dropped because the holding register was full.
- `busy`  output  1  FSM not in IDLE.

## Operation
- **Synchronizer**
  - `rx_in` passes through a 2-flop synchronizer; both flops reset to 1.
  - All logic uses the synchronized signal `rxs`.
- **Counters**
  - Baud counter `cnt`: width ceil(log2(DIV)).
  - Bit index `idx`: 3 bits.
  - Shift register `sh`: 8 bits, filled by right-shift so the LSB arrives first.
- **IDLE**
  - `cnt` = 0.
  - When `rxs`==0, go to START.
- **START**
  - `cnt` increments each cycle.
  - At `cnt`==HALF-1, sample `rxs`:
    - `rxs`==0: go to DATA with `cnt`=0, `idx`=0.
    - `rxs`==1: glitch; return to IDLE with no flag.
- **DATA**
  - At `cnt`==DIV-1: shift in `rxs`, set `cnt`=0, increment `idx`.
  - After the sample taken with `idx`==7, go to STOP.
- **STOP**
  - At `cnt`==DIV-1, sample `rxs`:
    - `rxs`==1: deliver `sh` (see holding register), then go to IDLE.
    - `rxs`==0: pulse `frame_err`, discard the byte, go to BRK.
- **BRK**
  - Wait for `rxs`==1, then go to IDLE.
  - A held-low line (break) yields exactly one `frame_err`.
- **Holding register**, evaluated in the delivery cycle:
  - `rx_valid`==0: load `rx_data`, set `rx_valid`.
  - `rx_valid`==1 and `rx_ready`==1 in the same cycle: old byte is consumed, new byte is loaded, `rx_valid` stays 1, no overrun.
  - `rx_valid`==1 and `rx_ready`==0: keep the old byte, pulse `overrun`.
  - Outside delivery cycles, `rx_valid & rx_ready` clears `rx_valid`.
  - `rx_data` is stable while `rx_valid`==1 and not handshaken.
- **busy**: 1 in START, DATA, STOP and BRK.

## Timing
- **Reset values** (async assert, sync release):
  - `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - FSM in IDLE; `cnt`, `idx` and `sh` = 0; synchronizer flops = 1.
- **Reset mid-frame**: abort immediately, with no flags and no partial byte. After release, a line still low is treated as a new start edge.
- **Latency**: if `rx_in` falls before clock edge E0, then:
  - `busy` rises at E0+3.
  - The start-bit sample is at E0+2+HALF.
  - Data bit n is sampled at E0+2+HALF+(n+1)·DIV.
  - `rx_valid` rises, or `frame_err`/`overrun` pulses, at E0+3+HALF+9·DIV.
  - Bench tolerance is ±1 cycle.
- Back-to-back frames are supported: IDLE is re-entered HALF cycles before the nominal stop-bit end, so the next start edge is never missed.
- Baud mismatch of up to ±2 % must still decode correctly, since sampling is at mid-bit.
- Flags are single-cycle pulses, registered, and never asserted in the same cycle as each other.
- All outputs are registered; there is no combinational path from `rx_in` or `rx_ready` to any output.

## Test plan
Benches use CLK_FREQ_HZ=100_000_000 and BAUD_RATE=1_000_000, giving DIV=100 and HALF=50.
- **Single byte**: send 0xA5 at 1 µs/bit, `rx_ready`=0. Expect:
  - `rx_valid` rises at E0+3+50+900 ±1.
  - `rx_data`=0xA5; no flags.
  - One-cycle `rx_ready` then clears `rx_valid`.
- **Back-to-back**: send 0x00, 0xFF, 0x55 with no idle gap, `rx_ready` tied 1. Expect three deliveries in order, with zero overrun and zero frame_err.
- **Glitch**: `rx_in` low for 30 cycles, then high. Expect:
  - `busy` high for ≤ 51 cycles, then back to IDLE.
  - No `rx_valid` and no flags.
- **Framing/break**: send 0x3C with the stop bit low, then hold the line low for 5 bit times. Expect:
  - Exactly one `frame_err` pulse and no `rx_valid`.
  - `busy` stays high until the line returns high.
- **Overrun and simultaneous accept**:
  - Send 0x11 then 0x22 with `rx_ready`=0. Expect `overrun` to pulse once and `rx_data` to remain 0x11.
  - Repeat with `rx_ready` pulsed exactly in the delivery cycle of 0x22. Expect no overrun, `rx_data`=0x22 and `rx_valid` still 1.
- **Reset mid-frame**: assert `rst_n`=0 during data bit 4 of 0xC3. Expect:
  - All outputs reach their reset values asynchronously.
  - After release with the line idle, a subsequent 0x96 is received correctly.
